// File: rtl/led_drv_pkg.sv
// rtl/led_drv_pkg.sv - shared constants and helpers for the LED bar driver
// Provides clog2 for level width derivation and the mode/range encodings
// used on iMODE and iRANGE.
package led_drv_pkg;

    localparam logic MODE_DOT   = 1'b0;
    localparam logic MODE_BAR   = 1'b1;
    localparam logic RANGE_HALF = 1'b0;
    localparam logic RANGE_FULL = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/led_bar_driver_if.sv
// rtl/led_bar_driver_if.sv - sample bus from the accelerometer reader
// Signals:
//   iDIG   signed sample, DATA_W bits
//   iVALID sample strobe
//   iRANGE 1 = full-range sample, 0 = half-range
//   iMODE  0 = dot pattern, 1 = bar pattern
// master drives the bus, slave (the LED driver) consumes it.
interface led_bar_driver_if #(
    parameter int DATA_W = 10
);

    logic signed [DATA_W-1:0] iDIG;
    logic                     iVALID;
    logic                     iRANGE;
    logic                     iMODE;

    modport master (output iDIG, output iVALID, output iRANGE, output iMODE);
    modport slave  (input  iDIG, input  iVALID, input  iRANGE, input  iMODE);

endinterface

// File: rtl/led_level_decoder.sv
// rtl/led_level_decoder.sv - level/sign/mode to centre-out LED pattern
// Ports:
//   level_i  magnitude level, clog2(LED_N) bits
//   sign_i   1 = negative side (LEDs below centre)
//   mode_i   dot or bar pattern
//   led_o    LED_N pattern, purely combinational
module led_level_decoder
    import led_drv_pkg::*;
#(
    parameter  int LED_N = 8,
    localparam int LVL_W = clog2(LED_N)
) (
    input  logic [LVL_W-1:0] level_i,
    input  logic             sign_i,
    input  logic             mode_i,
    output logic [LED_N-1:0] led_o
);

    localparam int H = LED_N / 2;

    // Every pattern is one contiguous run of LEDs [lo, hi]. The outer end is
    // the furthest dot-mode LED; the inner end is either the centre LED (bar),
    // the neighbour towards the centre (dot, even level), or the outer LED
    // itself (dot, odd level).
    always_comb begin
        int j;
        int outer;
        int inner;
        int lo;
        int hi;
        logic dual;

        j     = int'(level_i[LVL_W-1:1]);
        dual  = ~level_i[0];
        outer = 0;
        inner = 0;
        lo    = 0;
        hi    = 0;
        led_o = '0;

        if (!sign_i) begin
            outer = H + j;
            inner = (mode_i == MODE_BAR) ? (H - 1) : (dual ? (outer - 1) : outer);
            lo    = inner;
            hi    = outer;
        end else begin
            outer = H - 1 - j;
            inner = (mode_i == MODE_BAR) ? H : (dual ? (outer + 1) : outer);
            lo    = outer;
            hi    = inner;
        end

        for (int i = 0; i < LED_N; i++) begin
            led_o[i] = (i >= lo) && (i <= hi);
        end
    end

endmodule

// File: rtl/led_bar_driver.sv
// rtl/led_bar_driver.sv - signed accelerometer sample to LED bar/dot display
// Ports:
//   iCLK, iRSTN  clock, asynchronous active-low reset
//   smp          sample bus (iDIG, iVALID, iRANGE, iMODE), slave side
//   iINT         asynchronous activity interrupt, rising edge starts a flash
//   oLED         LED drive, registered
//   oACTIVE      high during the flash window, registered
//   oLEVEL       current level, registered
//   oSIGN        sign of the smoothed value, registered
module led_bar_driver
    import led_drv_pkg::*;
#(
    parameter  int DATA_W    = 10,
    parameter  int LED_N     = 8,
    parameter  int AVG_SHIFT = 0,
    parameter  int BLINK_W   = 24,
    parameter  int FLASH_BIT = 20,
    localparam int LVL_W     = clog2(LED_N)
) (
    input  logic              iCLK,
    input  logic              iRSTN,
    led_bar_driver_if.slave   smp,
    input  logic              iINT,
    output logic [LED_N-1:0]  oLED,
    output logic              oACTIVE,
    output logic [LVL_W-1:0]  oLEVEL,
    output logic              oSIGN
);

    logic signed [DATA_W-1:0] v_scaled;
    logic signed [DATA_W:0]   diff;
    logic signed [DATA_W:0]   diff_sh;
    logic signed [DATA_W-1:0] avg_q, avg_d;

    logic                     sign_c;
    logic [LVL_W-1:0]         level_c;
    logic [LED_N-1:0]         pattern_c;

    logic                     s0_q, s1_q, s2_q;
    logic [BLINK_W-1:0]       cnt_q, cnt_d;

    logic [LED_N-1:0]         led_q, led_d;
    logic                     active_q, active_d;
    logic [LVL_W-1:0]         level_q;
    logic                     sign_q;

    // Half-range samples saturate to the inner half of the code space and are
    // then doubled. The top two bits tell whether the sample is in range.
    always_comb begin
        v_scaled = smp.iDIG;
        if (smp.iRANGE != RANGE_FULL) begin
            case (smp.iDIG[DATA_W-1 -: 2])
                2'b01:   v_scaled = {1'b0, {(DATA_W-2){1'b1}}, 1'b0};
                2'b10:   v_scaled = {1'b1, {(DATA_W-1){1'b0}}};
                default: v_scaled = {smp.iDIG[DATA_W-2:0], 1'b0};
            endcase
        end
    end

    // Exponential smoothing. The difference needs one extra bit; after the
    // arithmetic shift the sum always lands back inside DATA_W.
    always_comb begin
        diff    = {v_scaled[DATA_W-1], v_scaled} - {avg_q[DATA_W-1], avg_q};
        diff_sh = diff >>> AVG_SHIFT;
        avg_d   = smp.iVALID ? DATA_W'(avg_q + diff_sh) : avg_q;
    end

    // One's complement magnitude keeps -1 and 0 at the same level, giving a
    // symmetric display around the centre.
    assign sign_c  = avg_q[DATA_W-1];
    assign level_c = sign_c ? ~avg_q[DATA_W-2 -: LVL_W] : avg_q[DATA_W-2 -: LVL_W];

    led_level_decoder #(
        .LED_N (LED_N)
    ) u_decoder (
        .level_i (level_c),
        .sign_i  (sign_c),
        .mode_i  (smp.iMODE),
        .led_o   (pattern_c)
    );

    // Counter MSB set means idle; a start clears it and it runs until the MSB
    // sets again, which gives a window of 2^(BLINK_W-1) cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (s1_q && !s2_q) begin
            cnt_d = '0;
        end else if (!cnt_q[BLINK_W-1]) begin
            cnt_d = cnt_q + BLINK_W'(1);
        end
    end

    always_comb begin
        active_d = ~cnt_q[BLINK_W-1];
        if (active_d) begin
            led_d = cnt_q[FLASH_BIT] ? '0 : '1;
        end else begin
            led_d = pattern_c;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            avg_q    <= '0;
            s0_q     <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            cnt_q    <= {1'b1, {(BLINK_W-1){1'b0}}};
            led_q    <= '0;
            active_q <= 1'b0;
            level_q  <= '0;
            sign_q   <= 1'b0;
        end else begin
            avg_q    <= avg_d;
            s0_q     <= iINT;
            s1_q     <= s0_q;
            s2_q     <= s1_q;
            cnt_q    <= cnt_d;
            led_q    <= led_d;
            active_q <= active_d;
            level_q  <= level_c;
            sign_q   <= sign_c;
        end
    end

    assign oLED    = led_q;
    assign oACTIVE = active_q;
    assign oLEVEL  = level_q;
    assign oSIGN   = sign_q;

endmodule

// File: tb/tb_led_bar_driver.sv
// tb/tb_led_bar_driver.sv - self-checking bench for led_bar_driver
module tb_led_bar_driver;

    localparam int DW  = 10;
    localparam int LN  = 8;
    localparam int BW  = 6;
    localparam int FB  = 3;
    localparam int WIN = 1 << (BW - 1);

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic iint = 1'b0;

    always #5 clk = ~clk;

    led_bar_driver_if #(.DATA_W(DW)) smp();

    logic [LN-1:0] led_a, led_b;
    logic          act_a, act_b;
    logic [2:0]    lvl_a, lvl_b;
    logic          sgn_a, sgn_b;

    led_bar_driver #(
        .DATA_W(DW), .LED_N(LN), .AVG_SHIFT(0), .BLINK_W(BW), .FLASH_BIT(FB)
    ) u_a (
        .iCLK(clk), .iRSTN(rstn), .smp(smp), .iINT(iint),
        .oLED(led_a), .oACTIVE(act_a), .oLEVEL(lvl_a), .oSIGN(sgn_a)
    );

    led_bar_driver #(
        .DATA_W(DW), .LED_N(LN), .AVG_SHIFT(2), .BLINK_W(BW), .FLASH_BIT(FB)
    ) u_b (
        .iCLK(clk), .iRSTN(rstn), .smp(smp), .iINT(iint),
        .oLED(led_b), .oACTIVE(act_b), .oLEVEL(lvl_b), .oSIGN(sgn_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int scale(input int d, input bit full);
        int c;
        if (full) return d;
        c = (d > 255) ? 255 : ((d < -256) ? -256 : d);
        return c * 2;
    endfunction

    function automatic int ema(input int a, input int v, input int s);
        return a + ((v - a) >>> s);
    endfunction

    function automatic int lvl_of(input int a);
        int mag;
        mag = (a < 0) ? (-a - 1) : a;
        return mag >> 6;
    endfunction

    // Pattern for the positive side, mirrored by bit reversal for negatives.
    function automatic logic [7:0] pat(input int a, input bit bar);
        int L;
        int j;
        int k;
        logic [7:0] p;
        logic [7:0] r;
        L = lvl_of(a);
        j = L / 2;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            k = i - 4;
            if (bar) p[i] = (k >= -1) && (k <= j);
            else     p[i] = (k == j) || ((L % 2 == 0) && (k == j - 1));
        end
        if (a >= 0) return p;
        for (int i = 0; i < 8; i++) r[i] = p[7 - i];
        return r;
    endfunction

    int         avg_m [2];
    int         shift_m [2];
    int         starts [$];
    bit         prev_int;
    int         e;
    logic [7:0] x_led [2];
    bit         x_act [2];
    int         x_lvl [2];
    bit         x_sgn [2];

    initial begin
        shift_m[0] = 0;
        shift_m[1] = 2;
    end

    // Counter-zero edge of the most recent start at or before edge 'at'.
    function automatic int window_pos(input int at);
        int best;
        best = -1;
        foreach (starts[i]) if (starts[i] <= at && starts[i] > best) best = starts[i];
        if (best < 0 || at - best >= WIN) return -1;
        return at - best;
    endfunction

    always @(posedge clk or negedge rstn) begin
        int w;
        if (!rstn) begin
            for (int k = 0; k < 2; k++) begin
                avg_m[k] = 0;
                x_led[k] = 8'h00;
                x_act[k] = 1'b0;
                x_lvl[k] = 0;
                x_sgn[k] = 1'b0;
            end
            starts.delete();
            prev_int = 1'b0;
            e = 0;
        end else begin
            e++;
            w = window_pos(e - 1);
            for (int k = 0; k < 2; k++) begin
                x_act[k] = (w >= 0);
                if (w >= 0) x_led[k] = ((w >> FB) & 1) ? 8'h00 : 8'hFF;
                else        x_led[k] = pat(avg_m[k], smp.iMODE);
                x_lvl[k] = lvl_of(avg_m[k]);
                x_sgn[k] = (avg_m[k] < 0);
            end
            if (smp.iVALID) begin
                for (int k = 0; k < 2; k++)
                    avg_m[k] = ema(avg_m[k], scale(int'(smp.iDIG), smp.iRANGE), shift_m[k]);
            end
            // sampled at e, synchroniser detects it and clears the counter at e+2
            if (iint && !prev_int) starts.push_back(e + 2);
            prev_int = iint;
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("a_led", led_a, x_led[0]);
            chk("a_act", act_a, x_act[0]);
            chk("a_lvl", lvl_a, x_lvl[0]);
            chk("a_sgn", sgn_a, x_sgn[0]);
            chk("b_led", led_b, x_led[1]);
            chk("b_act", act_b, x_act[1]);
            chk("b_lvl", lvl_b, x_lvl[1]);
            chk("b_sgn", sgn_b, x_sgn[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic put(input int d, input bit full, input bit bar);
        @(negedge clk);
        smp.iDIG   = d[DW-1:0];
        smp.iVALID = 1'b1;
        smp.iRANGE = full;
        smp.iMODE  = bar;
        @(negedge clk);
        smp.iVALID = 1'b0;
        @(negedge clk);
    endtask

    task automatic flash_run(input int retrig, output int cnt, output int first,
                             output logic [7:0] led4, output logic [7:0] led12,
                             output logic [7:0] led40);
        @(negedge clk);
        iint  = 1'b1;
        cnt   = 0;
        first = -1;
        led4  = 8'h00;
        led12 = 8'h00;
        led40 = 8'h00;
        for (int n = 1; n <= 90; n++) begin
            @(negedge clk);
            if (n == 1) iint = 1'b0;
            if (retrig > 0 && n == retrig) iint = 1'b1;
            if (retrig > 0 && n == retrig + 1) iint = 1'b0;
            if (act_a) begin
                cnt++;
                if (first < 0) first = n;
            end
            if (n == 4)  led4  = led_a;
            if (n == 12) led12 = led_a;
            if (n == 40) led40 = led_a;
        end
    endtask

    initial begin
        int cnt;
        int first;
        int hold;
        int r;
        logic [7:0] l4, l12, l40;

        smp.iDIG   = '0;
        smp.iVALID = 1'b0;
        smp.iRANGE = 1'b1;
        smp.iMODE  = 1'b0;

        #12;
        chk("rst_led", led_a, 0);
        chk("rst_act", act_a, 0);
        chk("rst_lvl", lvl_a, 0);
        chk("rst_sgn", sgn_a, 0);
        @(negedge clk);
        rstn = 1'b1;

        // full range, dot
        put(0, 1, 0);    chk("t1_zero", led_a, 8'h18);
        put(511, 1, 0);  chk("t1_pmax", led_a, 8'h80); chk("t1_pmax_lvl", lvl_a, 7);
        put(-512, 1, 0); chk("t1_nmax", led_a, 8'h01); chk("t1_nmax_sgn", sgn_a, 1);
        // bar
        put(511, 1, 1);  chk("t2_pbar", led_a, 8'hF8);
        put(-512, 1, 1); chk("t2_nbar", led_a, 8'h1F);
        put(64, 1, 1);   chk("t2_l1", led_a, 8'h18);
        put(128, 1, 1);  chk("t2_l2", led_a, 8'h38);
        // half range, dot
        put(300, 0, 0);  chk("t3_psat", led_a, 8'h80);
        put(-300, 0, 0); chk("t3_nsat", led_a, 8'h01);
        put(100, 0, 0);  chk("t3_mid", led_a, 8'h20); chk("t3_mid_lvl", lvl_a, 3);

        // activity window, single pulse
        flash_run(0, cnt, first, l4, l12, l40);
        chk("t5_first", first, 4);
        chk("t5_len", cnt, 32);
        chk("t5_on", l4, 8'hFF);
        chk("t5_off", l12, 8'h00);
        chk("t5_back", l40, 8'h20);
        // retrigger at window cycle 20
        flash_run(20, cnt, first, l4, l12, l40);
        chk("t5_retrig_len", cnt, 52);

        // reset in the middle of a window
        @(negedge clk); iint = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) iint = 1'b0;
        end
        chk("t6_pre_act", act_a, 1);
        #2 rstn = 1'b0;
        #1;
        chk("t6_rst_led", led_a, 0);
        chk("t6_rst_act", act_a, 0);
        smp.iDIG   = '0;
        smp.iVALID = 1'b1;
        smp.iRANGE = 1'b1;
        smp.iMODE  = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (act_a) cnt++;
            if (n == 2) chk("t6_after_led", led_a, 8'h18);
        end
        chk("t6_no_flash", cnt, 0);

        // smoothing step on the AVG_SHIFT=2 instance: avg 100,175,231,273
        @(negedge clk);
        smp.iDIG = 10'sd400;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 2) chk("t4_lvl100", lvl_b, 1);
            if (n == 3) chk("t4_lvl175", lvl_b, 2);
            if (n == 4) chk("t4_lvl231", lvl_b, 3);
            if (n == 5) chk("t4_lvl273", lvl_b, 4);
        end
        repeat (25) @(negedge clk);
        smp.iDIG = '0;
        repeat (10) @(negedge clk);

        // randomized traffic
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            r = int'($urandom_range(0, 1023));
            smp.iDIG   = r[DW-1:0];
            smp.iVALID = ($urandom_range(0, 3) != 0);
            smp.iRANGE = $urandom_range(0, 1) == 1;
            smp.iMODE  = $urandom_range(0, 1) == 1;
            if (hold > 0) begin
                hold--;
                if (hold == 0) iint = 1'b0;
            end else if ($urandom_range(0, 149) == 0) begin
                iint = 1'b1;
                hold = int'($urandom_range(1, 3));
            end
        end
        iint = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
